// File: rtl/dict_pkg.sv
// Shared constants and loader state encoding for the dictionary memory writer.
package dict_pkg;

    localparam int unsigned DICT_ADDR_W    = 12;
    localparam int unsigned DICT_DATA_W    = 32;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef logic [1:0] ld_state_t;

    localparam ld_state_t StIdle    = 2'd0;
    localparam ld_state_t StCollect = 2'd1;
    localparam ld_state_t StWrite   = 2'd2;
    localparam ld_state_t StDone    = 2'd3;

endpackage

// File: rtl/byte_packer.sv
// Assembles four little-endian bytes into one 32-bit word; word_valid_o marks the 4th byte.
module byte_packer
    import dict_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  idx_q;
    logic [31:0] word_q;

    // word_o already includes the byte being accepted this cycle.
    always_comb begin
        word_o                = word_q;
        word_o[8*idx_q +: 8]  = byte_i;
        word_valid_o          = byte_valid_i && (idx_q == 2'(BYTES_PER_WORD - 1));
    end

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (byte_valid_i) begin
            if (word_valid_o) begin
                idx_q  <= '0;
                word_q <= '0;
            end else begin
                idx_q  <= idx_q + 2'd1;
                word_q <= word_o;
            end
        end
    end

endmodule

// File: rtl/dict_mem_loader.sv
// Fills the dictionary RAM from a byte stream, one word per 5 cycles, from a programmable base.
module dict_mem_loader
    import dict_pkg::*;
#(
    parameter int unsigned ADDR_W = DICT_ADDR_W,
    parameter int unsigned DATA_W = DICT_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_wEn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dataIn,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MaxWords = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] One      = {{ADDR_W{1'b0}}, 1'b1};

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic        start_acc;
    logic        byte_acc;
    logic [31:0] packed_word;
    logic        packed_valid;

    assign in_ready   = (state_q == StCollect);
    assign mem_wEn    = (state_q == StWrite);
    assign busy       = (state_q == StCollect) || (state_q == StWrite);
    assign done       = (state_q == StDone);
    assign err        = err_q;
    assign mem_addr   = addr_q;
    assign mem_dataIn = data_q;
    assign byte_acc   = in_valid && in_ready;

    byte_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (start_acc),
        .byte_valid_i (byte_acc),
        .byte_i       (in_data),
        .word_o       (packed_word),
        .word_valid_o (packed_valid)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        widx_d    = widx_q;
        err_d     = err_q;
        addr_d    = addr_q;
        data_d    = data_q;
        start_acc = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    start_acc = 1'b1;
                    base_d    = base_addr;
                    count_d   = word_count;
                    widx_d    = '0;
                    err_d     = 1'b0;
                    if (word_count == '0) begin
                        state_d = StDone;
                    end else if (word_count > MaxWords) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (packed_valid) begin
                    // Address wraps silently modulo the RAM size.
                    addr_d  = base_q + widx_q[ADDR_W-1:0];
                    data_d  = DATA_W'(packed_word);
                    state_d = StWrite;
                end
            end
            StWrite: begin
                widx_d  = widx_q + One;
                state_d = (widx_q == count_q - One) ? StDone : StCollect;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            base_q  <= '0;
            count_q <= '0;
            widx_q  <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            widx_q  <= widx_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_dict_mem_loader.sv
// Directed bench for dict_mem_loader with a write scoreboard checked on every mem_wEn.
module tb_dict_mem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] word_count = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, mem_wEn, busy, done, err;
    logic [11:0] mem_addr;
    logic [31:0] mem_dataIn;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_writes = 0;
    int start_cyc = 0;
    int wr_cyc[$];
    logic [43:0] sb[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dict_mem_loader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_wEn    (mem_wEn),
        .mem_addr   (mem_addr),
        .mem_dataIn (mem_dataIn),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write must match the oldest pending expectation.
    always @(negedge clock) begin
        if (mem_wEn) begin
            logic [43:0] e;
            n_writes++;
            wr_cyc.push_back(cyc);
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            check("ready_low_in_write", 64'(in_ready), 64'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e[43:32]));
                check("wr_data", 64'(mem_dataIn), 64'(e[31:0]));
            end
        end
    end

    task automatic do_start(input logic [11:0] b, input logic [12:0] n);
        @(negedge clock);
        start = 1'b1; base_addr = b; word_count = n;
        start_cyc = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int bound;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clock);
        end
        in_valid = 1'b1; in_data = b;
        bound = 0;
        while (!in_ready && bound < 50) begin
            @(negedge clock);
            bound++;
        end
        if (bound >= 50) check("ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [11:0] a, input bit gaps);
        sb.push_back({a, w});
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic wait_done();
        int bound = 0;
        while (!done && bound < 200) begin
            @(negedge clock);
            bound++;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_wen"}, 64'(mem_wEn), 64'd0);
        check({tag, "_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_data"}, 64'(mem_dataIn), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        int w0;
        logic [31:0] words[3];
        words[0] = 32'hA1B2C3D4; words[1] = 32'h01020304; words[2] = 32'hFEDCBA98;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_reset_vals("rst");

        // Basic two-word load with full-rate input.
        do_start(12'h000, 13'd2);
        check("busy_after_start", 64'(busy), 64'd1);
        send_word(32'h44332211, 12'h000, 1'b0);
        send_word(32'h88776655, 12'h001, 1'b0);
        wait_done();
        check("t1_nwrites", 64'(wr_cyc.size()), 64'd2);
        if (wr_cyc.size() == 2) begin
            check("t1_wr0_cycle", 64'(wr_cyc[0] - start_cyc), 64'd5);
            check("t1_wr1_cycle", 64'(wr_cyc[1] - start_cyc), 64'd10);
        end
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_err", 64'(err), 64'd0);
        @(negedge clock);
        check("t1_done_sticky", 64'(done), 64'd1);

        // Address wrap-around.
        do_start(12'hFFF, 13'd2);
        check("t2_done_cleared", 64'(done), 64'd0);
        send_word(32'hCAFEF00D, 12'hFFF, 1'b0);
        send_word(32'h12345678, 12'h000, 1'b0);
        wait_done();
        check("t2_err", 64'(err), 64'd0);

        // Zero and oversize counts.
        w0 = n_writes;
        do_start(12'h055, 13'd0);
        check("t3_zero_done", 64'(done), 64'd1);
        check("t3_zero_err", 64'(err), 64'd0);
        do_start(12'h055, 13'd4097);
        check("t3_big_done", 64'(done), 64'd1);
        check("t3_big_err", 64'(err), 64'd1);
        repeat (3) @(negedge clock);
        check("t3_no_writes", 64'(n_writes - w0), 64'd0);

        // Random input gaps.
        do_start(12'h200, 13'd3);
        check("t4_err_cleared", 64'(err), 64'd0);
        for (int i = 0; i < 3; i++) send_word(words[i], 12'(12'h200 + i), 1'b1);
        wait_done();

        // Reset after two bytes of the first word.
        w0 = n_writes;
        do_start(12'h300, 13'd2);
        send_byte(8'h99, 0);
        send_byte(8'h98, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_reset_vals("midrst");
        repeat (6) @(negedge clock);
        check("midrst_no_write", 64'(n_writes - w0), 64'd0);
        do_start(12'h123, 13'd1);
        send_word(32'hDDCCBBAA, 12'h123, 1'b0);
        wait_done();

        // start during COLLECT must be ignored.
        do_start(12'h010, 13'd2);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        start = 1'b1; base_addr = 12'h500; word_count = 13'd1;
        @(negedge clock);
        start = 1'b0;
        check("t6_still_busy", 64'(busy), 64'd1);
        sb.push_back({12'h010, 32'h04030201});
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_word(32'h08070605, 12'h011, 1'b0);
        wait_done();
        check("t6_err", 64'(err), 64'd0);

        repeat (2) @(negedge clock);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
